// File: rtl/div3_sequencer.sv
// Sequences a nibble-serial divide-by-3 stage: accept, NIBBLES shift steps, capture, hold result.
// Accept-to-out_valid latency NIBBLES+1 cycles; result holds while out_ready is low, and no new dividend is accepted until it drains.
module div3_sequencer #(
    parameter int SIZE    = 20,
    parameter int NIBBLES = SIZE / 4
) (
    input  logic            sys_clock,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_dividend,
    output logic            in_ready,
    output logic            shift_en,
    output logic [2:0]      sel,
    output logic [SIZE-1:0] divident,
    input  logic [SIZE-1:0] quotient,
    input  logic [1:0]      reminder,
    output logic            out_valid,
    output logic [SIZE-1:0] out_quotient,
    output logic [1:0]      out_remainder,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'(NIBBLES);

    state_t     state;
    logic [2:0] step_cnt;

    // The step counter is the nibble select; it reads 0 outside SHIFT.
    assign sel = step_cnt;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            shift_en      <= 1'b0;
            step_cnt      <= 3'd0;
            divident      <= '0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= 2'd0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        divident <= in_dividend;
                        step_cnt <= 3'd1;
                        shift_en <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step_cnt == LAST_STEP) begin
                        step_cnt <= 3'd0;
                        shift_en <= 1'b0;
                        state    <= CAPTURE;
                    end else begin
                        step_cnt <= step_cnt + 3'd1;
                    end
                end
                CAPTURE: begin
                    // Stage still holds the final result during this cycle.
                    out_quotient  <= quotient;
                    out_remainder <= reminder;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
